// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, runs the
// imem req/ack handshake, absorbs stalls in a one-entry skid and bubbles on redirect.
module instr_fetch_stage #(
  parameter int unsigned           PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
  parameter logic [PC_WIDTH-1:0]   NOP_INSTR = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [PC_WIDTH-1:0] imem_data_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                stall_i,
  output logic [PC_WIDTH-1:0] pc_plus4_o,
  output logic [PC_WIDTH-1:0] instr_o,
  output logic [5:0]          instr_op_o,
  output logic                valid_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_BUFFERED = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [PC_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [PC_WIDTH-1:0] skid_pc4_q, skid_pc4_d;
  logic [PC_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic                redir_pend_q, redir_pend_d;
  logic [PC_WIDTH-1:0] redir_tgt_q, redir_tgt_d;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] target_aligned;

  assign pc_plus4       = pc_q + PC_STEP;
  assign target_aligned = {branch_target_i[PC_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;

    // A redirect flushes IF/ID even under stall; a bubble keeps pc_plus4 as is.
    if (branch_taken_i) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (branch_taken_i) pc_d = target_aligned;
      end

      ST_FETCH: begin
        if (imem_ack_i) begin
          if (branch_taken_i) begin
            pc_d         = target_aligned;
            redir_pend_d = 1'b0;
          end else if (redir_pend_q) begin
            pc_d         = redir_tgt_q;
            redir_pend_d = 1'b0;
            if (!stall_i) begin
              ifid_valid_d = 1'b0;
              ifid_instr_d = NOP_INSTR;
            end
          end else if (!stall_i) begin
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_data_i;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            skid_pc4_d   = pc_plus4;
            skid_instr_d = imem_data_i;
            pc_d         = pc_plus4;
            state_d      = ST_BUFFERED;
          end
        end else if (branch_taken_i) begin
          // Address must stay put until the ack, so remember where to go instead.
          redir_pend_d = 1'b1;
          redir_tgt_d  = target_aligned;
        end else if (!stall_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end

      ST_BUFFERED: begin
        if (branch_taken_i) begin
          pc_d    = target_aligned;
          state_d = ST_FETCH;
        end else if (!stall_i) begin
          ifid_pc4_d   = skid_pc4_q;
          ifid_instr_d = skid_instr_q;
          ifid_valid_d = 1'b1;
          state_d      = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      skid_pc4_q   <= '0;
      skid_instr_q <= NOP_INSTR;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  assign imem_req_o  = (state_q == ST_FETCH);
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = ifid_pc4_q;
  assign instr_o     = ifid_instr_q;
  assign instr_op_o  = ifid_instr_q[PC_WIDTH-1 -: 6];
  assign valid_o     = ifid_valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a latency-programmable imem responder,
// an expected-instruction queue, and a monitor that checks each consumed IF/ID entry.
module tb_instr_fetch_stage;

  localparam logic [31:0] WORD_A   = 32'h2008_0005;
  localparam logic [31:0] WORD_B   = 32'h8C09_0004;
  localparam logic [31:0] WORD_C   = 32'hAC0A_0008;
  localparam logic [31:0] WORD_12  = 32'h012A_5820;
  localparam logic [31:0] WORD_16  = 32'h1109_FFFE;
  localparam logic [31:0] WORD_D   = 32'h0800_0010;
  localparam logic [31:0] WORD_40  = 32'h3C01_1234;
  localparam logic [31:0] WORD_E   = 32'h3421_5678;
  localparam logic [31:0] WORD_F   = 32'hFC00_0ABC;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        stall_i;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic        valid_o;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;

  int   waitCycles = 0;
  int   ackLimit   = 0;
  int   ackCount   = 0;
  bit   manualMode = 1'b0;
  logic lateAck    = 1'b0;
  logic [31:0] lateData = '0;

  instr_fetch_stage #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_data_i    (imem_data_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .stall_i        (stall_i),
    .pc_plus4_o     (pc_plus4_o),
    .instr_o        (instr_o),
    .instr_op_o     (instr_op_o),
    .valid_o        (valid_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return WORD_A;
      32'h0000_0004: return WORD_B;
      32'h0000_0008: return WORD_C;
      32'h0000_000C: return WORD_12;
      32'h0000_0010: return WORD_16;
      32'h0000_0014: return WORD_D;
      32'h0000_0040: return WORD_40;
      32'h0000_0044: return WORD_E;
      32'hFFFF_FFFC: return WORD_F;
      default:       return {16'hBAD0, addr[15:0]};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [31:0] pc4, input logic [31:0] instr);
    exp_t e;
    e.pc4   = pc4;
    e.instr = instr;
    expQ.push_back(e);
  endtask

  // Drives inputs just after a rising edge, then parks on the falling edge for checks.
  task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic stall);
    branch_taken_i  = br;
    branch_target_i = tgt;
    stall_i         = stall;
    @(negedge clk_i);
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      stepClock();
      n++;
    end
    checkOutput("drain_queue", 32'(expQ.size()), 32'd0);
  endtask

  // Memory model: acks after waitCycles idle request cycles, up to ackLimit words.
  initial begin
    int waitCnt = 0;
    imem_ack_i  = 1'b0;
    imem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (manualMode) begin
        imem_ack_i  = lateAck;
        imem_data_i = lateData;
      end else if (!rst_i || !imem_req_o || ackCount >= ackLimit) begin
        imem_ack_i = 1'b0;
        waitCnt    = 0;
      end else if (waitCnt >= waitCycles) begin
        imem_ack_i  = 1'b1;
        imem_data_i = memWord(imem_addr_o);
        waitCnt     = 0;
        ackCount++;
      end else begin
        imem_ack_i = 1'b0;
        waitCnt++;
      end
    end
  end

  // An IF/ID entry is consumed when it is valid and downstream is not stalling.
  initial begin
    exp_t e;
    logic [31:0] expOp;
    forever begin
      @(negedge clk_i);
      if (rst_i && valid_o && !stall_i) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_instr", instr_o, 32'h0000_0000);
        end else begin
          e = expQ.pop_front();
          expOp = {26'd0, e.instr[31:26]};
          checkOutput("sb_pc_plus4", pc_plus4_o, e.pc4);
          checkOutput("sb_instr", instr_o, e.instr);
          checkOutput("sb_opcode", {26'd0, instr_op_o}, expOp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i           = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    stall_i         = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("reset_req", {31'd0, imem_req_o}, 32'd0);
    checkOutput("reset_addr", imem_addr_o, 32'h0000_0000);
    checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset_instr", instr_o, 32'h0000_0000);
    checkOutput("reset_pc4", pc_plus4_o, 32'h0000_0000);
    checkOutput("reset_op", {26'd0, instr_op_o}, 32'd0);
    stepClock();

    $display("[TB] back-to-back fetch, zero latency");
    waitCycles = 0;
    ackLimit   = ackCount + 3;
    pushExp(32'h4, WORD_A);
    pushExp(32'h8, WORD_B);
    pushExp(32'hC, WORD_C);
    rst_i = 1'b1;
    waitDrain(20);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("idle_wait_addr", imem_addr_o, 32'hC);
    checkOutput("idle_wait_req", {31'd0, imem_req_o}, 32'd1);
    checkOutput("idle_wait_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("idle_wait_pc4", pc_plus4_o, 32'hC);
    stepClock();

    $display("[TB] three-cycle ack latency");
    waitCycles = 2;
    ackLimit   = ackCount + 2;
    pushExp(32'h10, WORD_12);
    pushExp(32'h14, WORD_16);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("lat3_addr_hold", imem_addr_o, 32'hC);
      stepClock();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("lat3_next_addr", imem_addr_o, 32'h10);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("lat3_bubble1_valid", {31'd0, valid_o}, 32'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("lat3_bubble2_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("lat3_bubble2_instr", instr_o, 32'h0);
    stepClock();
    waitDrain(10);

    $display("[TB] stall across an ack fills the skid");
    waitCycles = 1;
    ackLimit   = ackCount + 1;
    pushExp(32'h18, WORD_D);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("stall_pc4_hold", pc_plus4_o, 32'h14);
      checkOutput("stall_valid_hold", {31'd0, valid_o}, 32'd0);
      if (i >= 3) checkOutput("stall_buffered_req", {31'd0, imem_req_o}, 32'd0);
      stepClock();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("release_req_low", {31'd0, imem_req_o}, 32'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("resume_addr", imem_addr_o, 32'h18);
    checkOutput("resume_req", {31'd0, imem_req_o}, 32'd1);
    stepClock();

    $display("[TB] redirects while a fetch is outstanding");
    applyStimulus(1'b1, 32'h10, 1'b0);
    stepClock();
    waitCycles = 0;
    ackLimit   = ackCount + 1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pend_addr_stable", imem_addr_o, 32'h18);
    checkOutput("pend_req", {31'd0, imem_req_o}, 32'd1);
    stepClock();
    waitCycles = 1;
    ackLimit   = ackCount + 2;
    applyStimulus(1'b1, 32'h40, 1'b0);
    checkOutput("redir1_addr", imem_addr_o, 32'h10);
    checkOutput("redir1_valid", {31'd0, valid_o}, 32'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redir2_addr_hold", imem_addr_o, 32'h10);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redir2_addr", imem_addr_o, 32'h40);
    checkOutput("redir2_valid", {31'd0, valid_o}, 32'd0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redir2_wait_valid", {31'd0, valid_o}, 32'd0);
    stepClock();

    $display("[TB] redirect during stall drops the skid");
    waitCycles = 0;
    ackLimit   = ackCount + 1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("w40_valid", {31'd0, valid_o}, 32'd1);
    checkOutput("w40_instr", instr_o, WORD_40);
    checkOutput("w40_pc4", pc_plus4_o, 32'h44);
    checkOutput("w40_op", {26'd0, instr_op_o}, 32'h0F);
    stepClock();
    applyStimulus(1'b1, 32'h43, 1'b1);
    checkOutput("skid_req", {31'd0, imem_req_o}, 32'd0);
    checkOutput("skid_ifid_hold", instr_o, WORD_40);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("flush_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("flush_instr", instr_o, 32'h0);
    checkOutput("flush_pc4", pc_plus4_o, 32'h44);
    checkOutput("flush_addr", imem_addr_o, 32'h40);
    checkOutput("flush_req", {31'd0, imem_req_o}, 32'd1);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("skid_dropped", {31'd0, valid_o}, 32'd0);
    stepClock();

    $display("[TB] PC wrap and reset mid-handshake");
    waitCycles = 0;
    ackLimit   = ackCount + 1;
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    stepClock();
    ackLimit = ackCount + 2;
    pushExp(32'h0, WORD_F);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_fetch_addr", imem_addr_o, 32'hFFFF_FFFC);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_next_addr", imem_addr_o, 32'h0);
    checkOutput("wrap_pc4", pc_plus4_o, 32'h0);
    stepClock();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("pre_reset_instr", instr_o, WORD_A);
    checkOutput("pre_reset_pc4", pc_plus4_o, 32'h4);
    checkOutput("pre_reset_addr", imem_addr_o, 32'h4);
    #2;
    manualMode = 1'b1;
    lateAck    = 1'b1;
    lateData   = 32'hDEAD_BEEF;
    rst_i      = 1'b0;
    #1;
    checkOutput("async_reset_req", {31'd0, imem_req_o}, 32'd0);
    checkOutput("async_reset_addr", imem_addr_o, 32'h0);
    checkOutput("async_reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("async_reset_instr", instr_o, 32'h0);
    checkOutput("async_reset_pc4", pc_plus4_o, 32'h0);
    stepClock();
    stepClock();
    stall_i = 1'b0;
    rst_i   = 1'b1;
    stepClock();
    lateAck = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("late_ack_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("late_ack_instr", instr_o, 32'h0);
    checkOutput("late_ack_req", {31'd0, imem_req_o}, 32'd1);
    checkOutput("late_ack_addr", imem_addr_o, 32'h0);
    stepClock();

    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the main opcode decoder and drives the decoder's 6-bit opcode input. The block owns the PC and fetches words from an instruction memory over a req/ack handshake with variable latency. It absorbs back-pressure (stall) with a one-entry skid buffer and performs branch redirect with a bubble insert.

Parameters:
PC_WIDTH, 32, width of PC, addresses and data words
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
imem_req_o  out  1  fetch request to instruction memory
imem_addr_o  out  PC_WIDTH  fetch address (current PC)
imem_ack_i  in  1  memory response valid; imem_data_i is valid this cycle
imem_data_i  in  PC_WIDTH  fetched instruction word
branch_taken_i  in  1  one-cycle redirect pulse (Branch & ALU zero)
branch_target_i  in  PC_WIDTH  redirect target
stall_i  in  1  downstream hold; IF/ID must not change
pc_plus4_o  out  PC_WIDTH  IF/ID: fetched PC + 4
instr_o  out  PC_WIDTH  IF/ID: instruction word
instr_op_o  out  6  instr_o[31:26], to the decoder opcode input
valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst_i=0, async): pc=RESET_PC, state=IDLE, imem_req_o=0, valid_o=0, instr_o=NOP_INSTR, pc_plus4_o=0, skid empty, redir_pend=0.
- States: IDLE, FETCH, BUFFERED. All outputs are registered or decoded from state (Moore). imem_addr_o=pc always.
- IDLE: req=0. Moves to FETCH unconditionally on the first clock after reset release.
- FETCH: req=1. Address stays stable until ack (memory contract).
  - On ack, no redirect, stall=0: IF/ID <= {pc+4, data}, valid=1, pc<=pc+4, remain FETCH, and the next request issues the following cycle.
  - On ack, no redirect, stall=1: skid <= {pc+4, data}, pc<=pc+4, go BUFFERED.
  - No ack, stall=0: IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc_plus4 unchanged).
  - No ack, stall=1: IF/ID holds.
- BUFFERED: req=0. When stall=0, IF/ID <= skid, valid=1, go FETCH. While stall=1, everything holds.
- Redirect (branch_taken_i=1), which has priority over stall for the IF/ID flush:
  - IF/ID <= bubble in that cycle even if stall=1.
  - In FETCH with ack the same cycle: discard data, pc<=target.
  - In FETCH without ack: set redir_pend and latch the target. The address stays unchanged. On the eventual ack, discard data, pc<=latched target, clear redir_pend. No IF/ID load occurs.
  - In BUFFERED: discard skid, pc<=target, go FETCH.
  - In IDLE: pc<=target.
- A second redirect while redir_pend=1 overwrites the latched target.
- Target low two bits are forced to 00. PC arithmetic is modulo 2^PC_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0.
- Async reset mid-handshake abandons any in-flight request. Any late ack while in IDLE is ignored.
- instr_op_o is a pure slice of instr_o, so a bubble presents opcode 0.

Test Plan:
- Reset release, imem ack at 0-cycle latency with words A,B,C at 0,4,8 -> instr_o=A,B,C on successive cycles; pc_plus4_o=4,8,12; valid_o=1; instr_op_o=A[31:26].
- Ack latency 3 cycles -> imem_addr_o stable for 3 cycles; 2 bubble cycles (valid_o=0, instr_o=0) between instructions.
- stall_i=1 for 4 cycles coinciding with an ack of word D -> IF/ID unchanged, state BUFFERED, req=0; after release, instr_o=D next cycle, then fetch resumes at D's PC+4.
- branch_taken_i with target 32'h40 while a 2-cycle fetch at 0x10 is outstanding -> returned data discarded, next imem_addr_o=32'h40, valid_o=0 until the word at 0x40 arrives.
- Target 32'h43, redirect during stall with BUFFERED skid -> skid dropped, IF/ID bubbled, next address 32'h40.
- PC at 32'hFFFF_FFFC fetched -> pc_plus4_o=0 and next address 0; assert rst_i low mid-wait -> outputs at reset values immediately, no IF/ID load from late ack.
